branch_redirect: RTL and testbench

Consumes resolved branch/jump results from the Branch execution unit and compares each resolved target against the target the front-end predicted. On a mispredict it pulses a tagged pipeline flush, waits out a drain window, then drives a redirect PC to fetch with a valid/ready handshake. It sits between the branch execution unit's result bus and the fetch/ROB control path, and keeps branch and mispredict statistics counters.

---
 rtl/branch_redirect.sv | 135 +++++++++++++
 tb/tb_branch_redirect.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect.sv
// Compares resolved branch targets with the front-end prediction; on a mispredict it
// pulses a tagged flush, waits a drain window, then hands a redirect PC to fetch.
module branch_redirect #(
   parameter int TAG_WIDTH    = 6,
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 i_clock,
   input  logic                 i_reset_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [31:0]          i_address,
   input  logic [31:0]          i_jump_result,
   input  logic [31:0]          i_predicted,
   input  logic [TAG_WIDTH-1:0] i_tag,
   input  logic                 i_global_flush,
   input  logic                 i_fetch_ready,
   output logic                 o_flush,
   output logic [TAG_WIDTH-1:0] o_flush_tag,
   output logic                 o_redirect_valid,
   output logic [31:0]          o_redirect_address,
   output logic                 o_misaligned,
   output logic [CNT_WIDTH-1:0] o_branch_count,
   output logic [CNT_WIDTH-1:0] o_mispredict_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLUSH    = 2'd1,
      DRAIN    = 2'd2,
      REDIRECT = 2'd3
   } state_t;

   state_t                 state_reg, state_next;
   logic [3:0]             drain_reg, drain_next;
   logic [TAG_WIDTH-1:0]   tag_reg, tag_next;
   logic [31:0]            addr_reg, addr_next;
   logic                   misaligned_reg, misaligned_next;
   logic [CNT_WIDTH-1:0]   branch_cnt_reg, branch_cnt_next;
   logic [CNT_WIDTH-1:0]   mispredict_cnt_reg, mispredict_cnt_next;

   logic accept;
   logic target_misaligned;
   logic target_mismatch;

   // The branch PC travels with the result but no decision depends on it.
   logic unused_address;
   assign unused_address = ^i_address;

   assign o_ready           = (state_reg == IDLE) & ~i_global_flush;
   assign accept            = i_valid & o_ready;
   assign target_misaligned = (i_jump_result[1:0] != 2'b00);
   assign target_mismatch   = (i_jump_result != i_predicted);

   always_comb begin
      state_next          = state_reg;
      drain_next          = drain_reg;
      tag_next            = tag_reg;
      addr_next           = addr_reg;
      misaligned_next     = 1'b0;
      branch_cnt_next     = branch_cnt_reg;
      mispredict_cnt_next = mispredict_cnt_reg;

      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (branch_cnt_reg != {CNT_WIDTH{1'b1}})
                  branch_cnt_next = branch_cnt_reg + CNT_WIDTH'(1);
               if (target_misaligned || target_mismatch) begin
                  tag_next = i_tag;
                  if (mispredict_cnt_reg != {CNT_WIDTH{1'b1}})
                     mispredict_cnt_next = mispredict_cnt_reg + CNT_WIDTH'(1);
               end
               // A misaligned target is reported but never redirected to.
               if (target_misaligned) begin
                  misaligned_next = 1'b1;
               end else if (target_mismatch) begin
                  addr_next  = i_jump_result;
                  state_next = FLUSH;
               end
            end
         end
         FLUSH: begin
            state_next = DRAIN;
            drain_next = 4'(DRAIN_CYCLES - 1);
         end
         DRAIN: begin
            if (drain_reg == 4'd0)
               state_next = REDIRECT;
            else
               drain_next = drain_reg - 4'd1;
         end
         REDIRECT: begin
            if (i_fetch_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // An external flush wins over everything except the statistics.
      if (i_global_flush) begin
         state_next      = IDLE;
         misaligned_next = 1'b0;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_reg          <= IDLE;
         drain_reg          <= 4'd0;
         tag_reg            <= '0;
         addr_reg           <= 32'd0;
         misaligned_reg     <= 1'b0;
         branch_cnt_reg     <= '0;
         mispredict_cnt_reg <= '0;
      end else begin
         state_reg          <= state_next;
         drain_reg          <= drain_next;
         tag_reg            <= tag_next;
         addr_reg           <= addr_next;
         misaligned_reg     <= misaligned_next;
         branch_cnt_reg     <= branch_cnt_next;
         mispredict_cnt_reg <= mispredict_cnt_next;
      end
   end

   assign o_flush            = (state_reg == FLUSH);
   assign o_redirect_valid   = (state_reg == REDIRECT);
   assign o_flush_tag        = tag_reg;
   assign o_redirect_address = addr_reg;
   assign o_misaligned       = misaligned_reg;
   assign o_branch_count     = branch_cnt_reg;
   assign o_mispredict_count = mispredict_cnt_reg;

endmodule

// File: tb/tb_branch_redirect.sv
// Directed bench for branch_redirect: prediction hits, mispredict timing, fetch
// back-pressure, misaligned targets, global flush abort, reset and counter saturation.
module tb_branch_redirect;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid, ready;
   logic [31:0] address, jump_result, predicted;
   logic [5:0]  tag;
   logic        gflush, fetch_ready;
   logic        flush, rvalid, misaligned;
   logic [5:0]  flush_tag;
   logic [31:0] raddr;
   logic [15:0] bcnt, mcnt;

   // Narrow-counter instance for saturation checks
   logic        valid2, ready2, fetch_ready2;
   logic [31:0] jump_result2, predicted2;
   logic        flush2, rvalid2, misaligned2;
   logic [5:0]  flush_tag2;
   logic [31:0] raddr2;
   logic [3:0]  bcnt2, mcnt2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_redirect #(.TAG_WIDTH(6), .DRAIN_CYCLES(2), .CNT_WIDTH(16)) dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_valid(valid), .o_ready(ready),
      .i_address(address), .i_jump_result(jump_result), .i_predicted(predicted),
      .i_tag(tag), .i_global_flush(gflush), .i_fetch_ready(fetch_ready),
      .o_flush(flush), .o_flush_tag(flush_tag), .o_redirect_valid(rvalid),
      .o_redirect_address(raddr), .o_misaligned(misaligned),
      .o_branch_count(bcnt), .o_mispredict_count(mcnt)
   );

   branch_redirect #(.TAG_WIDTH(6), .DRAIN_CYCLES(2), .CNT_WIDTH(4)) dut2 (
      .i_clock(clk), .i_reset_n(rst_n), .i_valid(valid2), .o_ready(ready2),
      .i_address(32'h0000_0400), .i_jump_result(jump_result2), .i_predicted(predicted2),
      .i_tag(6'd1), .i_global_flush(1'b0), .i_fetch_ready(fetch_ready2),
      .o_flush(flush2), .o_flush_tag(flush_tag2), .o_redirect_valid(rvalid2),
      .o_redirect_address(raddr2), .o_misaligned(misaligned2),
      .o_branch_count(bcnt2), .o_mispredict_count(mcnt2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; valid = 1'b0; address = '0; jump_result = '0; predicted = '0;
      tag = '0; gflush = 1'b0; fetch_ready = 1'b0;
      valid2 = 1'b0; jump_result2 = '0; predicted2 = '0; fetch_ready2 = 1'b1;
      #12;
      chk("rst_ready", 32'(ready), 1);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_raddr", raddr, 0);
      chk("rst_tag", 32'(flush_tag), 0);
      chk("rst_bcnt", 32'(bcnt), 0);
      chk("rst_mcnt", 32'(mcnt), 0);
      rst_n = 1'b1;
      tick();

      // Correct prediction
      valid = 1'b1; address = 32'h100; jump_result = 32'h104; predicted = 32'h104; tag = 6'd2;
      tick();
      valid = 1'b0;
      $display("txn hit: addr=0x100 target=0x104");
      chk("hit_ready", 32'(ready), 1);
      chk("hit_flush", 32'(flush), 0);
      chk("hit_rvalid", 32'(rvalid), 0);
      chk("hit_bcnt", 32'(bcnt), 1);
      chk("hit_mcnt", 32'(mcnt), 0);

      // Mispredict with fetch ready: flush next cycle, redirect 4 cycles after accept
      valid = 1'b1; jump_result = 32'h200; predicted = 32'h104; tag = 6'd5; fetch_ready = 1'b1;
      tick();
      valid = 1'b0;
      $display("txn mispredict: tag=5 target=0x200");
      chk("mp_flush", 32'(flush), 1);
      chk("mp_flush_tag", 32'(flush_tag), 5);
      chk("mp_mcnt", 32'(mcnt), 1);
      chk("mp_ready_busy", 32'(ready), 0);
      tick();
      chk("mp_flush_1cyc", 32'(flush), 0);
      chk("mp_drain1_rvalid", 32'(rvalid), 0);
      tick();
      chk("mp_drain2_rvalid", 32'(rvalid), 0);
      tick();
      chk("mp_rvalid", 32'(rvalid), 1);
      chk("mp_raddr", raddr, 32'h200);
      tick();
      chk("mp_done_rvalid", 32'(rvalid), 0);
      chk("mp_done_ready", 32'(ready), 1);
      chk("mp_bcnt", 32'(bcnt), 2);

      // Mispredict with fetch stalled for 5 cycles; a blocked result must not count
      valid = 1'b1; jump_result = 32'h200; predicted = 32'h300; tag = 6'd7; fetch_ready = 1'b0;
      tick();
      jump_result = 32'h500; predicted = 32'h600;
      $display("txn mispredict stalled: tag=7 target=0x200");
      tick(); tick(); tick();
      for (int i = 0; i < 5; i++) begin
         chk("stall_rvalid", 32'(rvalid), 1);
         chk("stall_raddr", raddr, 32'h200);
         chk("stall_ready", 32'(ready), 0);
         tick();
      end
      valid = 1'b0;
      fetch_ready = 1'b1;
      tick();
      fetch_ready = 1'b0;
      chk("stall_done_ready", 32'(ready), 1);
      chk("stall_done_rvalid", 32'(rvalid), 0);
      chk("stall_bcnt", 32'(bcnt), 3);
      chk("stall_mcnt", 32'(mcnt), 2);

      // Misaligned target
      valid = 1'b1; jump_result = 32'h202; predicted = 32'h202; tag = 6'd3;
      tick();
      valid = 1'b0;
      $display("txn misaligned: tag=3 target=0x202");
      chk("mis_pulse", 32'(misaligned), 1);
      chk("mis_tag", 32'(flush_tag), 3);
      chk("mis_flush", 32'(flush), 0);
      chk("mis_ready", 32'(ready), 1);
      chk("mis_mcnt", 32'(mcnt), 3);
      chk("mis_bcnt", 32'(bcnt), 4);
      tick();
      chk("mis_pulse_end", 32'(misaligned), 0);
      chk("mis_rvalid", 32'(rvalid), 0);

      // Global flush during DRAIN, with a valid result held alongside it
      valid = 1'b1; jump_result = 32'h400; predicted = 32'h500; tag = 6'd9;
      tick();
      valid = 1'b0;
      tick();
      $display("txn global flush in drain: tag=9");
      gflush = 1'b1; valid = 1'b1; jump_result = 32'h800; predicted = 32'h900;
      chk("gf_ready_low", 32'(ready), 0);
      tick();
      chk("gf_rvalid", 32'(rvalid), 0);
      chk("gf_flush", 32'(flush), 0);
      gflush = 1'b0; valid = 1'b0;
      #1;
      chk("gf_ready_back", 32'(ready), 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("gf_no_redirect", 32'(rvalid), 0);
      end
      chk("gf_bcnt", 32'(bcnt), 5);
      chk("gf_mcnt", 32'(mcnt), 4);

      // Saturation on the 4-bit instance: 15 back-to-back misaligned accepts
      valid2 = 1'b1; jump_result2 = 32'h202; predicted2 = 32'h0;
      repeat (14) tick();
      chk("sat_bcnt_14", 32'(bcnt2), 14);
      chk("sat_mcnt_14", 32'(mcnt2), 14);
      tick();
      valid2 = 1'b0;
      chk("sat_bcnt_15", 32'(bcnt2), 15);
      chk("sat_mcnt_15", 32'(mcnt2), 15);
      for (int m = 0; m < 3; m++) begin
         valid2 = 1'b1; jump_result2 = 32'h200; predicted2 = 32'h300;
         tick();
         valid2 = 1'b0;
         $display("txn saturated mispredict %0d", m);
         for (int k = 0; k < 10 && !ready2; k++) tick();
         chk("sat_ready_back", 32'(ready2), 1);
      end
      chk("sat_bcnt_hold", 32'(bcnt2), 15);
      chk("sat_mcnt_hold", 32'(mcnt2), 15);

      // Reset asserted mid-sequence returns everything immediately
      valid = 1'b1; jump_result = 32'h700; predicted = 32'h704; tag = 6'd11;
      tick();
      valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      $display("txn async reset during drain");
      chk("ares_ready", 32'(ready), 1);
      chk("ares_bcnt", 32'(bcnt), 0);
      chk("ares_mcnt", 32'(mcnt), 0);
      chk("ares_raddr", raddr, 0);
      chk("ares_tag", 32'(flush_tag), 0);
      rst_n = 1'b1;
      tick();
      tick();
      chk("ares_no_redirect", 32'(rvalid), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
